// File: rtl/rocket_trace_pkg.sv
// Shared types for the retire trace buffer: the stored entry layout and the
// gap-tracking state encoding.
// Optional feature macro: ROCKET_TRACE_TIMESTAMP_EN adds a 32-bit push timestamp
// field to every entry.
package rocket_trace_pkg;

  localparam int TRC_XLEN = 64;

  typedef struct packed {
    logic [TRC_XLEN-1:0] pc;
    logic [31:0]         insn;
    logic                wen;
    logic [4:0]          waddr;
    logic [TRC_XLEN-1:0] wdata;
    logic                exc;
    logic                gap;
`ifdef ROCKET_TRACE_TIMESTAMP_EN
    logic [31:0]         ts;
`endif
  } rocket_trace_entry_t;

  typedef enum logic {
    TRC_NORMAL,
    TRC_DROPPING
  } trc_state_t;

endpackage

// File: rtl/rocket_retire_trace_buffer_if.sv
// Retire-side capture bus and trace-side valid/ready drain bus.
// slave modport: the trace buffer; master modport: the core/BFM environment.
// Optional feature macro: ROCKET_TRACE_TIMESTAMP_EN adds trace_time.
interface rocket_retire_trace_buffer_if #(
  parameter int XLEN = 64
);
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic [31:0]     retire_insn;
  logic            retire_wen;
  logic [4:0]      retire_waddr;
  logic [XLEN-1:0] retire_wdata;
  logic            retire_exc;

  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     trace_insn;
  logic            trace_wen;
  logic [4:0]      trace_waddr;
  logic [XLEN-1:0] trace_wdata;
  logic            trace_exc;
  logic            trace_gap;
`ifdef ROCKET_TRACE_TIMESTAMP_EN
  logic [31:0]     trace_time;
`endif

  modport slave (
    input  retire_valid, retire_pc, retire_insn, retire_wen, retire_waddr,
           retire_wdata, retire_exc, trace_ready,
    output trace_valid, trace_pc, trace_insn, trace_wen, trace_waddr,
           trace_wdata, trace_exc, trace_gap
`ifdef ROCKET_TRACE_TIMESTAMP_EN
    , output trace_time
`endif
  );

  modport master (
    output retire_valid, retire_pc, retire_insn, retire_wen, retire_waddr,
           retire_wdata, retire_exc, trace_ready,
    input  trace_valid, trace_pc, trace_insn, trace_wen, trace_waddr,
           trace_wdata, trace_exc, trace_gap
`ifdef ROCKET_TRACE_TIMESTAMP_EN
    , input trace_time
`endif
  );

endinterface

// File: rtl/rocket_trace_fifo.sv
// Generic synchronous FIFO, entry type and depth parameterised.
// Simultaneous push and pop are accepted, including while full. The head is
// presented as zero while empty so downstream fields read as reset values.
module rocket_trace_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  // Occupancy flags and gated push/pop.
  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? T'('0) : mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rocket_retire_trace_buffer.sv
// Per-core retire trace buffer. Commit-stage events are queued for the trace
// BFM; when the queue is full events are dropped (never stalling the core),
// counted, and the next stored entry is tagged with gap.
// Optional feature macro: ROCKET_TRACE_TIMESTAMP_EN adds a free-running cycle
// counter whose value at push time is stored per entry and shown on trace_time.
//
// Gap state | meaning
// ----------+-------------------------------------------------------------
// NORMAL    | no drop since the last stored entry
// DROPPING  | at least one event dropped; next pushed entry gets gap=1
module rocket_retire_trace_buffer
  import rocket_trace_pkg::*;
#(
  parameter int XLEN  = TRC_XLEN,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  rocket_retire_trace_buffer_if.slave   bus,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          overflow
);
  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  rocket_trace_entry_t wr_entry;
  rocket_trace_entry_t rd_entry;
  trc_state_t          state_q;
  trc_state_t          state_d;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                room;
  logic                push;
  logic                drop;
`ifdef ROCKET_TRACE_TIMESTAMP_EN
  logic [31:0]         cycle_cnt;
`endif

  // Handshake decode; clear overrides both push and pop.
  always_comb begin
    pop  = !fifo_empty && bus.trace_ready && !clear;
    room = !fifo_full || pop;
    push = bus.retire_valid && room && !clear;
    drop = bus.retire_valid && !room && !clear;
  end

  // Pack the retiring event into an entry, tagged with the pending-gap flag.
  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = bus.retire_pc;
    wr_entry.insn  = bus.retire_insn;
    wr_entry.wen   = bus.retire_wen;
    wr_entry.waddr = bus.retire_waddr;
    wr_entry.wdata = bus.retire_wdata;
    wr_entry.exc   = bus.retire_exc;
    wr_entry.gap   = (state_q == TRC_DROPPING);
`ifdef ROCKET_TRACE_TIMESTAMP_EN
    wr_entry.ts    = cycle_cnt;
`endif
  end

  rocket_trace_fifo #(
    .T     (rocket_trace_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .din     (wr_entry),
    .dout    (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head entry drives the trace port directly from registered storage.
  always_comb begin
    bus.trace_valid = !fifo_empty;
    bus.trace_pc    = rd_entry.pc;
    bus.trace_insn  = rd_entry.insn;
    bus.trace_wen   = rd_entry.wen;
    bus.trace_waddr = rd_entry.waddr;
    bus.trace_wdata = rd_entry.wdata;
    bus.trace_exc   = rd_entry.exc;
    bus.trace_gap   = rd_entry.gap;
`ifdef ROCKET_TRACE_TIMESTAMP_EN
    bus.trace_time  = rd_entry.ts;
`endif
  end

  // Gap state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= TRC_NORMAL;
    else          state_q <= state_d;
  end

  // Gap next-state: enter on a drop, leave on the push that carries the gap.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = TRC_NORMAL;
    end else begin
      case (state_q)
        TRC_NORMAL:   if (drop) state_d = TRC_DROPPING;
        TRC_DROPPING: if (push) state_d = TRC_NORMAL;
        default:      state_d = TRC_NORMAL;
      endcase
    end
  end

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef ROCKET_TRACE_TIMESTAMP_EN
  // Free-running cycle counter, wraps at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cycle_cnt <= '0;
    else if (clear) cycle_cnt <= '0;
    else            cycle_cnt <= cycle_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rocket_retire_trace_buffer.sv
// Directed bench for rocket_retire_trace_buffer: single retire latency,
// overflow/gap tagging, full push+pop, drop-counter saturation (CNT_W=4),
// clear priority and asynchronous reset.
module tb_rocket_retire_trace_buffer;
  logic clk;
  logic reset_n;
  logic clear;
  logic clear4;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic [3:0]  drop_cnt4;
  logic        overflow4;
  int checks;
  int failures;

  rocket_retire_trace_buffer_if #(.XLEN(64)) bus0 ();
  rocket_retire_trace_buffer_if #(.XLEN(64)) bus4 ();

  rocket_retire_trace_buffer #(.XLEN(64), .DEPTH(16), .CNT_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .bus      (bus0.slave),
    .drop_cnt (drop_cnt),
    .overflow (overflow)
  );

  rocket_retire_trace_buffer #(.XLEN(64), .DEPTH(16), .CNT_W(4)) dut4 (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear4),
    .bus      (bus4.slave),
    .drop_cnt (drop_cnt4),
    .overflow (overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [63:0] pc, input logic [31:0] insn);
    bus0.retire_valid = v;
    bus0.retire_pc    = pc;
    bus0.retire_insn  = insn;
    bus0.retire_wen   = 1'b1;
    bus0.retire_waddr = 5'(insn);
    bus0.retire_wdata = pc ^ 64'hFFFF;
    bus0.retire_exc   = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    clear = 1'b0;
    clear4 = 1'b0;
    drive0(1'b0, 64'h0, 32'h0);
    bus0.trace_ready = 1'b0;
    bus4.retire_valid = 1'b0;
    bus4.retire_pc = 64'h0;
    bus4.retire_insn = 32'h0;
    bus4.retire_wen = 1'b0;
    bus4.retire_waddr = 5'h0;
    bus4.retire_wdata = 64'h0;
    bus4.retire_exc = 1'b0;
    bus4.trace_ready = 1'b0;
    #23;
    reset_n = 1'b1;
    step();

    // Reset state
    chk("rst_valid", 64'(bus0.trace_valid), 64'd0);
    chk("rst_gap", 64'(bus0.trace_gap), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_pc", bus0.trace_pc, 64'd0);

    // Single retire, one cycle latency
    bus0.trace_ready = 1'b1;
    drive0(1'b1, 64'h8000_0000, 32'h0000_0013);
    bus0.retire_exc = 1'b1;
    chk("t1_valid_before", 64'(bus0.trace_valid), 64'd0);
    step();
    drive0(1'b0, 64'h0, 32'h0);
    chk("t1_valid", 64'(bus0.trace_valid), 64'd1);
    chk("t1_pc", bus0.trace_pc, 64'h8000_0000);
    chk("t1_insn", 64'(bus0.trace_insn), 64'h13);
    chk("t1_waddr", 64'(bus0.trace_waddr), 64'h13);
    chk("t1_wdata", bus0.trace_wdata, 64'h8000_FFFF);
    chk("t1_exc", 64'(bus0.trace_exc), 64'd1);
    chk("t1_gap", 64'(bus0.trace_gap), 64'd0);
    chk("t1_drop", 64'(drop_cnt), 64'd0);
    step();
    chk("t1_popped", 64'(bus0.trace_valid), 64'd0);

    // 20 back-to-back retires, no ready: 16 held, 4 dropped
    bus0.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive0(1'b1, 64'h1000 + 64'(4 * i), 32'(i));
      step();
    end
    drive0(1'b0, 64'h0, 32'h0);
    chk("t2_drop", 64'(drop_cnt), 64'd4);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_valid", 64'(bus0.trace_valid), 64'd1);

    // Full: pop and retire in the same cycle is accepted without a drop
    bus0.trace_ready = 1'b1;
    drive0(1'b1, 64'h2000, 32'h77);
    chk("t2_head0_pc", bus0.trace_pc, 64'h1000);
    chk("t2_head0_gap", 64'(bus0.trace_gap), 64'd0);
    step();
    drive0(1'b0, 64'h0, 32'h0);
    chk("t3_drop_same", 64'(drop_cnt), 64'd4);
    for (int i = 1; i < 16; i++) begin
      chk("t2_drain_pc", bus0.trace_pc, 64'h1000 + 64'(4 * i));
      chk("t2_drain_gap", 64'(bus0.trace_gap), 64'd0);
      step();
    end
    chk("t2_17_valid", 64'(bus0.trace_valid), 64'd1);
    chk("t2_17_pc", bus0.trace_pc, 64'h2000);
    chk("t2_17_gap", 64'(bus0.trace_gap), 64'd1);
    step();
    chk("t2_empty", 64'(bus0.trace_valid), 64'd0);
    chk("t2_ovf_sticky", 64'(overflow), 64'd1);

    // Clear with 5 buffered entries and a simultaneous retire
    bus0.trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive0(1'b1, 64'h3000 + 64'(4 * i), 32'(i));
      step();
    end
    chk("t5_valid_before", 64'(bus0.trace_valid), 64'd1);
    clear = 1'b1;
    drive0(1'b1, 64'h4000, 32'h55);
    step();
    clear = 1'b0;
    drive0(1'b0, 64'h0, 32'h0);
    chk("t5_valid", 64'(bus0.trace_valid), 64'd0);
    chk("t5_drop", 64'(drop_cnt), 64'd0);
    chk("t5_ovf", 64'(overflow), 64'd0);
    bus0.trace_ready = 1'b1;
    step();
    chk("t5_not_stored", 64'(bus0.trace_valid), 64'd0);

    // CNT_W=4 saturation: 16 stored, then 20 drops
    bus4.retire_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus4.retire_pc = 64'(i);
      step();
    end
    chk("t4_drop14", 64'(drop_cnt4), 64'd14);
    step();
    chk("t4_drop15", 64'(drop_cnt4), 64'd15);
    for (int i = 0; i < 5; i++) step();
    bus4.retire_valid = 1'b0;
    chk("t4_sat", 64'(drop_cnt4), 64'd15);
    chk("t4_ovf", 64'(overflow4), 64'd1);
    chk("t4_valid", 64'(bus4.trace_valid), 64'd1);

    // Asynchronous reset with 3 entries held
    bus0.trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 64'h5000 + 64'(4 * i), 32'(i));
      step();
    end
    drive0(1'b0, 64'h0, 32'h0);
    chk("t6_valid_before", 64'(bus0.trace_valid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", 64'(bus0.trace_valid), 64'd0);
    chk("t6_pc", bus0.trace_pc, 64'd0);
    chk("t6_gap", 64'(bus0.trace_gap), 64'd0);
    chk("t6_valid4", 64'(bus4.trace_valid), 64'd0);
    chk("t6_drop4", 64'(drop_cnt4), 64'd0);
    chk("t6_ovf4", 64'(overflow4), 64'd0);
    #2;
    reset_n = 1'b1;
    step();
    chk("t6_after_edge", 64'(bus0.trace_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rocket_retire_trace_buffer.md
# rocket_retire_trace_buffer

Captures per-core instruction-retirement events from a Rocket core's commit stage and buffers them for the RocketBFM monitor downstream. The BFM drains entries at its own pace through a valid/ready handshake. One instance sits alongside each core (core0..core3) inside the Rocket core hierarchy. It feeds the BFM's trace port, so that back-pressure from the testbench side never stalls the core. When the buffer is full, events are dropped and counted instead of stalling, and the next delivered entry is flagged as following a gap.

## Interface
- `XLEN`, 64, width of PC and writeback data
- `DEPTH`, 16, FIFO entries; power of two, minimum 2
- `CNT_W`, 16, width of the drop counter
- `clk` in 1: core clock
- `reset_n` in 1: reset, asynchronous assert, active-low
- `retire_valid` in 1: one instruction retires this cycle
- `retire_pc` in XLEN: PC of the retiring instruction
- `retire_insn` in 32: instruction encoding
- `retire_wen` in 1: integer register writeback is valid
- `retire_waddr` in 5: destination register
- `retire_wdata` in XLEN: writeback value
- `retire_exc` in 1: the instruction raised an exception
- `trace_valid` out 1: head entry is available
- `trace_ready` in 1: BFM accepts the head entry
- `trace_pc`, `trace_insn`, `trace_wen`, `trace_waddr`, `trace_wdata`, `trace_exc` out: head entry fields, same widths as the inputs
- `trace_gap` out 1: one or more events were dropped immediately before this entry
- `drop_cnt` out CNT_W: number of dropped events, saturating
- `overflow` out 1: sticky; set by the first drop
- `clear` in 1: synchronous; empties the FIFO and zeroes `drop_cnt`, `overflow` and the pending-gap state

## Operation
- Push: `retire_valid` is high and the FIFO has room. The event fields are captured into the tail entry, with `gap` set to the value of the pending-gap flag. The pending-gap flag is then cleared.
- Pop: `trace_valid && trace_ready`. The head entry advances.
- Room rule: the FIFO has room if it is not full, or if a pop occurs in the same cycle. Push and pop while full are therefore both accepted, and the count is unchanged.
- Drop: `retire_valid` is high and the FIFO has no room. The event is discarded, the pending-gap flag is set, and `overflow` is set.
  - `drop_cnt` increments by 1 and saturates at 2^CNT_W−1. It never wraps.
- Gap state machine, two states:
  - NORMAL → DROPPING on a drop.
  - DROPPING → NORMAL on the next push. That pushed entry carries `gap`=1.
  - The pending-gap flag is true exactly in DROPPING.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. An extra occupancy bit, or a count of log2(DEPTH)+1 bits, distinguishes full from empty.
- `clear` takes priority over push and pop in the same cycle. It returns the block to the reset state, and an event retiring in that cycle is discarded without being counted.
- `trace_*` fields are don't-care while `trace_valid`=0. Once `trace_valid` is high they are stable until the pop.

## Timing
- Reset values:
  - `trace_valid`=0, `trace_gap`=0, `drop_cnt`=0, `overflow`=0
  - all other `trace_*` outputs 0
  - FIFO empty, gap state NORMAL
- Latency: an event pushed into an empty FIFO at edge N appears on `trace_valid` after edge N. There is no combinational bypass from `retire_*` to `trace_*`.
- `trace_valid` depends only on registered state. `trace_ready` has no combinational path to any output.
- Throughput: one push and one pop per cycle sustained.
- If `reset_n` is asserted mid-operation, all state clears immediately. Buffered entries are lost and no pop is reported.

## Configuration
- `ROCKET_TRACE_TIMESTAMP_EN` defined:
  - A free-running 32-bit cycle counter is added. It resets to 0 and wraps.
  - Each entry stores the counter value at its push cycle.
  - The value is presented on the extra output `trace_time` [31:0].
  - `clear` also zeroes the counter.
- Undefined: no counter, no `trace_time` port, and entry width is unchanged.

## Structure
- Package `rocket_trace_pkg` holds:
  - typedef `rocket_trace_entry_t`: a packed struct of pc, insn, wen, waddr, wdata, exc and gap, plus time under the macro
  - the gap state enum `{TRC_NORMAL, TRC_DROPPING}`
- Sub-module `rocket_trace_fifo`: a generic synchronous FIFO parameterised by entry type and DEPTH. It exposes full/empty and accepts push and pop in the same cycle.

## Test plan
- Single retire, pc=0x8000_0000, insn=0x0000_0013, `trace_ready`=1 → `trace_valid` high exactly one cycle later with matching fields; `gap`=0; `drop_cnt`=0.
- 20 back-to-back retires with `trace_ready`=0, DEPTH=16 → 16 entries held, `drop_cnt`=4, `overflow`=1. Then raise ready, retire one more event, and drain: 16 original entries in order with `gap`=0, then a 17th entry with `gap`=1.
- FIFO full, retire and pop in the same cycle → event accepted, `drop_cnt` unchanged, occupancy stays 16.
- `drop_cnt` preset near the limit with CNT_W=4 (20 drops) → `drop_cnt` holds at 15.
- `clear` asserted with 5 entries buffered and a retire in the same cycle → next cycle `trace_valid`=0, `drop_cnt`=0, `overflow`=0; the retire is neither stored nor counted.
- `reset_n` pulsed low asynchronously between edges with 3 entries held → outputs go to reset values before the next edge. With `ROCKET_TRACE_TIMESTAMP_EN`, the first post-reset entry pushed at cycle 7 shows `trace_time`=7.
